// File: rtl/prog_feeder_pkg.sv
// Shared definitions for the program feeder: FSM states, opcode and halt constants.
// Consumed by prog_feeder; the watchdog limit only matters when FEEDER_WATCHDOG_EN is defined.
package feeder_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_ISSUE,
      S_EXEC,
      S_HALTED
   } feeder_state_t;

   localparam logic [2:0]  OP_MVI            = 3'b001;
   localparam logic [15:0] HALT_WORD_DEFAULT = 16'h007F;
   localparam int          WDOG_LIMIT        = 7;

   function automatic logic is_mvi(input logic [15:0] word);
      return word[15:13] == OP_MVI;
   endfunction

endpackage

// File: rtl/prog_feeder_pc_counter.sv
// Program counter for the feeder: async clear, synchronous clear-to-zero, and a
// load that advances by one or two words (two skips over an mvi immediate).
module pc_counter #(
   parameter int ADDR_W = 5
) (
   input  logic              Clock,
   input  logic              Resetn,
   input  logic              clear,
   input  logic              load,
   input  logic              step_two,
   output logic [ADDR_W-1:0] count,
   output logic [ADDR_W-1:0] count_plus1
);

   logic [ADDR_W-1:0] incr;

   assign incr        = step_two ? ADDR_W'(2) : ADDR_W'(1);
   assign count_plus1 = count + ADDR_W'(1);

   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (load) begin
         count <= count + incr;
      end
   end

endmodule

// File: rtl/prog_feeder.sv
// Instruction-stream front end: fetches words from a synchronous ROM and drives DIN/Run.
// Define FEEDER_WATCHDOG_EN to add the EXEC watchdog and the Error output.
module prog_feeder
   import feeder_pkg::*;
#(
   parameter int          ADDR_W    = 5,
   parameter logic [15:0] HALT_WORD = HALT_WORD_DEFAULT
) (
   input  logic              Clock,
   input  logic              Resetn,
   input  logic              Start,
   input  logic              Done,
   input  logic [15:0]       mem_data,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [15:0]       DIN,
   output logic              Run,
   output logic              Busy,
   output logic              Halted,
`ifdef FEEDER_WATCHDOG_EN
   output logic              Error,
`endif
   output logic [ADDR_W-1:0] pc
);

   feeder_state_t     state, state_next;
   logic [15:0]       instr;
   logic              latch_instr;
   logic              pc_clear, pc_load, pc_two;
   logic [ADDR_W-1:0] pc_plus1;
   logic              is_halt_word, word_is_mvi, instr_is_mvi;
   logic              wdog_trip;

   assign is_halt_word = (mem_data == HALT_WORD);
   assign word_is_mvi  = is_mvi(mem_data);
   assign instr_is_mvi = is_mvi(instr);

   pc_counter #(.ADDR_W(ADDR_W)) u_pc (
      .Clock       (Clock),
      .Resetn      (Resetn),
      .clear       (pc_clear),
      .load        (pc_load),
      .step_two    (pc_two),
      .count       (pc),
      .count_plus1 (pc_plus1)
   );

`ifdef FEEDER_WATCHDOG_EN
   logic [2:0] wdog_count;

   // Counts EXEC cycles that pass without Done; restarts on every new instruction.
   assign wdog_trip = (state == S_EXEC) && !Done && (wdog_count == 3'(WDOG_LIMIT - 1));

   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         wdog_count <= '0;
      end else if (state != S_EXEC) begin
         wdog_count <= '0;
      end else if (!Done) begin
         wdog_count <= wdog_count + 3'd1;
      end
   end

   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         Error <= 1'b0;
      end else if ((state == S_IDLE || state == S_HALTED) && Start) begin
         Error <= 1'b0;
      end else if (wdog_trip) begin
         Error <= 1'b1;
      end
   end
`else
   assign wdog_trip = 1'b0;
`endif

   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         state <= S_IDLE;
         instr <= '0;
      end else begin
         state <= state_next;
         if (latch_instr) begin
            instr <= mem_data;
         end
      end
   end

   // Run stays high from ISSUE through the cycle Done is sampled, since the processor
   // clears its step counter whenever Run is low.
   always_comb begin
      state_next  = state;
      Run         = 1'b0;
      DIN         = '0;
      mem_addr    = pc;
      latch_instr = 1'b0;
      pc_clear    = 1'b0;
      pc_load     = 1'b0;
      pc_two      = 1'b0;
      unique case (state)
         S_IDLE, S_HALTED: begin
            if (Start) begin
               pc_clear   = 1'b1;
               state_next = S_FETCH;
            end
         end
         S_FETCH: begin
            state_next = S_ISSUE;
         end
         S_ISSUE: begin
            if (is_halt_word) begin
               state_next = S_HALTED;
            end else begin
               Run         = 1'b1;
               DIN         = mem_data;
               latch_instr = 1'b1;
               state_next  = S_EXEC;
               if (word_is_mvi) begin
                  mem_addr = pc_plus1;
               end
            end
         end
         S_EXEC: begin
            Run = 1'b1;
            DIN = instr_is_mvi ? mem_data : instr;
            if (Done) begin
               pc_load    = 1'b1;
               pc_two     = instr_is_mvi;
               state_next = S_FETCH;
            end else if (wdog_trip) begin
               state_next = S_HALTED;
            end
         end
         default: begin
            state_next = S_IDLE;
         end
      endcase
   end

   assign Busy   = (state == S_FETCH) || (state == S_ISSUE) || (state == S_EXEC);
   assign Halted = (state == S_HALTED);

endmodule

// File: tb/tb_prog_feeder.sv
// Self-checking bench for prog_feeder: ROM and processor models, a cycle reference model,
// directed programs with literal expectations, then randomized programs and stimulus.
module tb_prog_feeder;

   localparam int          ADDR_W = 5;
   localparam int          DEPTH  = 32;
   localparam logic [15:0] HALT   = 16'h007F;
   localparam int          WDOG   = 7;

   logic              Clock    = 1'b0;
   logic              Resetn   = 1'b0;
   logic              Start    = 1'b0;
   logic              Done;
   logic [15:0]       mem_data = 16'h0000;
   logic [ADDR_W-1:0] mem_addr;
   logic [15:0]       DIN;
   logic              Run, Busy, Halted;
   logic [ADDR_W-1:0] pc;
`ifdef FEEDER_WATCHDOG_EN
   logic              Error;
`endif

   logic [15:0] rom [DEPTH];
   int          checks = 0;
   int          errors = 0;

   prog_feeder #(.ADDR_W(ADDR_W), .HALT_WORD(HALT)) dut (
      .Clock    (Clock),
      .Resetn   (Resetn),
      .Start    (Start),
      .Done     (Done),
      .mem_data (mem_data),
      .mem_addr (mem_addr),
      .DIN      (DIN),
      .Run      (Run),
      .Busy     (Busy),
      .Halted   (Halted),
`ifdef FEEDER_WATCHDOG_EN
      .Error    (Error),
`endif
      .pc       (pc)
   );

   always #5 Clock = ~Clock;

   always @(posedge Clock) mem_data <= rom[mem_addr];

   // Processor stand-in: Done at step 1 for mv/mvi, step 3 for ALU ops, plus optional slack.
   int   step      = 0;
   int   doneStep  = 1;
   int   extraMax  = 0;
   logic procEnable = 1'b1;
   logic noiseEn    = 1'b0;
   logic noiseBit   = 1'b0;

   always @(posedge Clock) begin
      if (!Run) step <= 0;
      else      step <= step + 1;
      if (Run && step == 0)
         doneStep <= ((DIN[15:13] == 3'b000 || DIN[15:13] == 3'b001) ? 1 : 3)
                     + int'($urandom_range(0, 32'(extraMax)));
      noiseBit <= noiseEn && ($urandom_range(0, 3) == 0);
   end

   assign Done = (procEnable && Run && step != 0 && step == doneStep) || (step == 0 && noiseBit);

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic applyStimulus(input logic s);
      @(posedge Clock);
      #1 Start = s;
   endtask

   // Reference model: tracks where the feeder is within an instruction and what the ROM returns.
   typedef enum int {M_IDLE, M_FETCH, M_ISSUE, M_EXEC, M_HALTED} mphase_t;
   mphase_t           mPhase   = M_IDLE;
   int                mPc      = 0;
   int                mExecCnt = 0;
   logic [15:0]       mInstr   = 16'h0000;
   logic [15:0]       mMem     = 16'h0000;
   logic              mErr     = 1'b0;
   logic              mRun, mBusy, mHalted, mIsMvi;
   logic [ADDR_W-1:0] mAddr;
   logic [15:0]       mDin;

   always @(negedge Clock) begin
      if (!Resetn) begin
         mPhase = M_IDLE;
         mPc    = 0;
         mErr   = 1'b0;
         mInstr = 16'h0000;
      end
      mIsMvi  = (mInstr[15:13] == 3'b001);
      mRun    = (mPhase == M_ISSUE && mMem != HALT) || mPhase == M_EXEC;
      mBusy   = (mPhase == M_FETCH || mPhase == M_ISSUE || mPhase == M_EXEC);
      mHalted = (mPhase == M_HALTED);
      mAddr   = ADDR_W'(mPc);
      if (mPhase == M_ISSUE && mMem[15:13] == 3'b001) mAddr = ADDR_W'((mPc + 1) % DEPTH);
      mDin    = (mPhase == M_ISSUE) ? mMem : (mIsMvi ? mMem : mInstr);

      checkOutput("Run", 32'(Run), 32'(mRun));
      checkOutput("Busy", 32'(Busy), 32'(mBusy));
      checkOutput("Halted", 32'(Halted), 32'(mHalted));
      checkOutput("pc", 32'(pc), 32'(mPc));
      checkOutput("mem_addr", 32'(mem_addr), 32'(mAddr));
      if (mRun) checkOutput("DIN", 32'(DIN), 32'(mDin));
`ifdef FEEDER_WATCHDOG_EN
      checkOutput("Error", 32'(Error), 32'(mErr));
`endif

      if (Resetn) begin
         case (mPhase)
            M_IDLE, M_HALTED: if (Start) begin
               mPc    = 0;
               mErr   = 1'b0;
               mPhase = M_FETCH;
            end
            M_FETCH: mPhase = M_ISSUE;
            M_ISSUE: begin
               if (mMem == HALT) begin
                  mPhase = M_HALTED;
               end else begin
                  mInstr   = mMem;
                  mExecCnt = 0;
                  mPhase   = M_EXEC;
               end
            end
            M_EXEC: begin
               if (Done) begin
                  mPc    = (mPc + (mIsMvi ? 2 : 1)) % DEPTH;
                  mPhase = M_FETCH;
               end else begin
                  mExecCnt++;
`ifdef FEEDER_WATCHDOG_EN
                  if (mExecCnt == WDOG) begin
                     mErr   = 1'b1;
                     mPhase = M_HALTED;
                  end
`endif
               end
            end
            default: mPhase = M_IDLE;
         endcase
      end
      mMem = rom[mAddr];
   end

   task automatic loadRom(input logic [15:0] w0, input logic [15:0] w1, input logic [15:0] w2);
      @(posedge Clock);
      #1;
      for (int a = 0; a < DEPTH; a++) rom[a] = HALT;
      rom[0] = w0;
      rom[1] = w1;
      rom[2] = w2;
   endtask

   logic [15:0] dinLog [$];

   // Starts the program and samples each cycle until Halted; Start is re-pulsed at busyStartAt.
   task automatic runProgram(input int budget, input int busyStartAt, output int busyCycles,
                             output int runCycles, output int maxStreak, output bit timedOut);
      int streak = 0;
      busyCycles = 0;
      runCycles  = 0;
      maxStreak  = 0;
      timedOut   = 1'b1;
      dinLog.delete();
      applyStimulus(1'b1);
      for (int i = 0; i < budget; i++) begin
         @(posedge Clock);
         #1;
         Start = (busyStartAt >= 0) && (i == busyStartAt || i == busyStartAt + 1);
         if (Busy) busyCycles++;
         if (Run) begin
            runCycles++;
            streak++;
            dinLog.push_back(DIN);
            if (streak > maxStreak) maxStreak = streak;
         end else begin
            streak = 0;
         end
         if (Halted) begin
            timedOut = 1'b0;
            break;
         end
      end
      Start = 1'b0;
      checkOutput("haltReached", 32'(timedOut), 32'd0);
   endtask

   function automatic logic [15:0] randWord();
      logic [15:0] w;
      int kind;
      kind = int'($urandom_range(0, 2));
      w    = 16'($urandom);
      case (kind)
         0:       w[15:13] = 3'b000;
         1:       w[15:13] = 3'b001;
         default: w[15:13] = 3'($urandom_range(2, 7));
      endcase
      if (w == HALT) w = 16'h0000;
      return w;
   endfunction

   initial begin
      int  busyC, runC, streakC, rstAt;
      bit  tout, armed, sawIssue, checkedImm;

      for (int a = 0; a < DEPTH; a++) rom[a] = HALT;
      $display("[TB] reset");
      repeat (3) @(posedge Clock);
      #1 Resetn = 1'b1;
      @(negedge Clock);
      checkOutput("rstRun", 32'(Run), 32'd0);
      checkOutput("rstBusy", 32'(Busy), 32'd0);
      checkOutput("rstHalted", 32'(Halted), 32'd0);
      checkOutput("rstPc", 32'(pc), 32'd0);
      checkOutput("rstAddr", 32'(mem_addr), 32'd0);

      $display("[TB] mvi then halt");
      loadRom(16'h2000, 16'h0005, HALT);
      runProgram(40, -1, busyC, runC, streakC, tout);
      checkOutput("mviBusyCycles", 32'(busyC), 32'd5);
      checkOutput("mviRunCycles", 32'(runC), 32'd2);
      checkOutput("mviDinCount", 32'(dinLog.size()), 32'd2);
      if (dinLog.size() == 2) begin
         checkOutput("mviDin0", 32'(dinLog[0]), 32'h2000);
         checkOutput("mviDin1", 32'(dinLog[1]), 32'h0005);
      end
      checkOutput("mviPc", 32'(pc), 32'd2);

      $display("[TB] add then halt, restart from HALTED");
      loadRom(16'h4500, HALT, HALT);
      runProgram(40, -1, busyC, runC, streakC, tout);
      checkOutput("addBusyCycles", 32'(busyC), 32'd7);
      checkOutput("addRunStreak", 32'(streakC), 32'd4);
      checkOutput("addPc", 32'(pc), 32'd1);
      checkOutput("addHalted", 32'(Halted), 32'd1);

      $display("[TB] Start while busy is ignored");
      runProgram(40, 1, busyC, runC, streakC, tout);
      checkOutput("busyStartCycles", 32'(busyC), 32'd7);
      checkOutput("busyStartPc", 32'(pc), 32'd1);

      $display("[TB] mvi at last address wraps");
      @(posedge Clock);
      #1;
      for (int a = 0; a < DEPTH - 1; a++) rom[a] = 16'h0200 | 16'(a);
      rom[DEPTH-1] = 16'h2000;
      applyStimulus(1'b1);
      armed = 1'b0; sawIssue = 1'b0; checkedImm = 1'b0; tout = 1'b1;
      for (int i = 0; i < 400; i++) begin
         @(posedge Clock);
         #1;
         Start = 1'b0;
         if (pc == ADDR_W'(DEPTH - 1) && !armed) begin
            rom[1] = HALT;
            armed  = 1'b1;
         end
         if (sawIssue && Run) begin
            checkOutput("wrapImmDin", 32'(DIN), 32'h0200);
            checkedImm = 1'b1;
            sawIssue   = 1'b0;
         end
         if (Run && pc == ADDR_W'(DEPTH - 1) && DIN == 16'h2000) begin
            checkOutput("wrapPrefetchAddr", 32'(mem_addr), 32'd0);
            sawIssue = 1'b1;
         end
         if (Halted) begin
            tout = 1'b0;
            break;
         end
      end
      checkOutput("wrapHalted", 32'(tout), 32'd0);
      checkOutput("wrapImmSeen", 32'(checkedImm), 32'd1);
      checkOutput("wrapPc", 32'(pc), 32'd1);

      $display("[TB] reset during EXEC");
      loadRom(16'h0200, 16'h4500, HALT);
      applyStimulus(1'b1);
      @(posedge Clock);
      #1 Start = 1'b0;
      repeat (5) @(posedge Clock);
      #1;
      checkOutput("preRstRun", 32'(Run), 32'd1);
      checkOutput("preRstPc", 32'(pc), 32'd1);
      #2 Resetn = 1'b0;
      #1;
      checkOutput("asyncRstRun", 32'(Run), 32'd0);
      checkOutput("asyncRstBusy", 32'(Busy), 32'd0);
      checkOutput("asyncRstPc", 32'(pc), 32'd0);
      @(negedge Clock);
      @(posedge Clock);
      #3 Resetn = 1'b1;
      @(negedge Clock);
      checkOutput("postRstBusy", 32'(Busy), 32'd0);
      checkOutput("postRstHalted", 32'(Halted), 32'd0);

`ifdef FEEDER_WATCHDOG_EN
      $display("[TB] watchdog");
      loadRom(16'h4500, HALT, HALT);
      procEnable = 1'b0;
      runProgram(40, -1, busyC, runC, streakC, tout);
      checkOutput("wdogRunCycles", 32'(runC), 32'(WDOG + 1));
      checkOutput("wdogError", 32'(Error), 32'd1);
      checkOutput("wdogHalted", 32'(Halted), 32'd1);
      checkOutput("wdogRun", 32'(Run), 32'd0);
      checkOutput("wdogPc", 32'(pc), 32'd0);
      procEnable = 1'b1;
      runProgram(40, -1, busyC, runC, streakC, tout);
      checkOutput("wdogCleared", 32'(Error), 32'd0);
`endif

      $display("[TB] randomized programs");
      noiseEn  = 1'b1;
      extraMax = 2;
      for (int r = 0; r < 30; r++) begin
         @(posedge Clock);
         #1;
         for (int a = 0; a < DEPTH; a++) rom[a] = randWord();
         rom[$urandom_range(4, DEPTH - 1)] = HALT;
         rstAt = ($urandom_range(0, 3) == 0) ? int'($urandom_range(10, 140)) : -1;
         for (int c = 0; c < 150; c++) begin
            Start  = ($urandom_range(0, 5) == 0);
            Resetn = (c != rstAt);
            @(posedge Clock);
            #1;
         end
      end
      Start  = 1'b0;
      Resetn = 1'b1;
      repeat (3) @(posedge Clock);
      @(negedge Clock);
      #1;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      errors++;
      $display("[TB] FAIL globalTimeout: got running, expected finished");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $fatal(1, "[TB] timeout");
   end

endmodule

// File: doc/prog_feeder.md
# prog_feeder

Instruction-stream front end for the 16-bit multi-cycle processor. It reads program words from a synchronous-read instruction ROM and drives the processor's `DIN` and `Run` inputs. It holds `Run` for the full duration of each instruction, supplies the immediate word during the second cycle of `mvi`, and advances the program counter when it samples the processor's `Done`. It stops when it fetches a halt marker.

## Interface
- `ADDR_W`, default 5, ROM address width; PC wraps modulo 2^ADDR_W.
- `HALT_WORD`, default 16'h007F, fetched word that stops execution. It decodes as mv R0,R0 with the unused bits [6:0] set, so it is never a meaningful instruction.
- `Clock` in 1: single clock, rising edge.
- `Resetn` in 1: asynchronous, active-low reset.
- `Start` in 1: begin execution at address 0. Honoured only in IDLE or HALTED.
- `Done` in 1: processor's combinational done; sampled at the rising edge.
- `mem_data` in 16: ROM read data, valid one cycle after `mem_addr`.
- `mem_addr` out ADDR_W: ROM address.
- `DIN` out 16: processor data/instruction input.
- `Run` out 1: processor run enable.
- `Busy` out 1: high in FETCH, ISSUE and EXEC.
- `Halted` out 1: high in HALTED.
- `Error` out 1: watchdog trip. Present only with `FEEDER_WATCHDOG_EN`.
- `pc` out ADDR_W: current program counter.

## Operation
- Opcode is `mem_data[15:13]`. MVI = 3'b001.
- States: IDLE, FETCH, ISSUE, EXEC, HALTED.
- IDLE / HALTED:
  - `Run`=0.
  - `Start`=1 → pc←0, clear `Error`, go to FETCH.
- FETCH:
  - `mem_addr`=pc, `Run`=0.
  - Go to ISSUE.
- ISSUE:
  - If `mem_data`==HALT_WORD: `Run`=0, go to HALTED, pc unchanged.
  - Otherwise: `Run`=1, `DIN`=`mem_data`, latch the word into `instr`, go to EXEC.
  - If the opcode is MVI, also drive `mem_addr`=pc+1 (wrapping) to prefetch the immediate.
- EXEC:
  - `Run`=1.
  - `DIN` = `mem_data` (the immediate) if `instr` is MVI, else `instr`.
  - On a sampled `Done`=1: pc←pc+2 for MVI, pc+1 otherwise (modulo 2^ADDR_W), then go to FETCH.
- `mem_addr` = pc in every state except ISSUE-with-MVI.
- Wrap-around: an MVI at the last address takes its immediate from address 0, and pc becomes 1.
- `Start` while `Busy` is ignored.
- `Done` outside EXEC is ignored.

## Timing
- Reset values:
  - state IDLE.
  - pc, `mem_addr`, `DIN`, `instr`: 0.
  - `Run`, `Busy`, `Halted`, `Error`: 0.
- Reset mid-instruction drops `Run` immediately (asynchronously), which makes the processor clear its step counter. No partial write is guaranteed beyond what the processor already committed.
- `Run` is never deasserted between ISSUE and the cycle in which `Done` is sampled. This is required because the processor clears its step counter whenever `Run` is low.
- Cycles per instruction: mv = 3, mvi = 3, ALU ops = 5. Breakdown: FETCH + ISSUE + the processor's post-IR steps.
- `Run` is low for exactly one cycle (FETCH) between consecutive instructions.
- `Halted` rises on the edge after ISSUE detects HALT_WORD.

## Configuration
- `FEEDER_WATCHDOG_EN` defined:
  - A 3-bit counter runs in EXEC.
  - 7 EXEC cycles without `Done` → `Run`=0, `Error`=1, go to HALTED, pc unchanged.
  - `Error` stays set until the next accepted `Start` or reset.
- Undefined: no counter, no `Error` port, and EXEC waits indefinitely.

## Structure
- Shared package `feeder_pkg` holds:
  - the state enum;
  - `OP_MVI` = 3'b001;
  - the `HALT_WORD` default;
  - `WDOG_LIMIT` = 7.
- One sub-module, `pc_counter`: ADDR_W wide, async clear, clear-to-zero input, increment-by-1/2 select, load enable.

## Test plan
- Program {mvi R0 (16'h2000), 16'h0005, 16'h007F}, then `Start`:
  - `Run` high for 2 cycles;
  - `DIN`=16'h2000 then 16'h0005;
  - pc=2;
  - `Halted`=1 after 5 cycles total.
- Program {add R1,R2 (16'h4500), HALT}, processor model asserting `Done` at step 3:
  - `Run` high 4 contiguous cycles;
  - pc 0→1;
  - `Halted` set.
- MVI placed at address 31 (ADDR_W=5): immediate is read from address 0, `DIN` equals ROM[0] in EXEC, pc becomes 1.
- `Resetn` pulsed low during the EXEC of an add: `Run`, `Busy` and pc are 0 immediately (async); the state is IDLE after release.
- `Start` pulsed while `Busy`: no effect on pc or state. `Start` while HALTED restarts at address 0.
- With `FEEDER_WATCHDOG_EN`, `Done` held at 0: `Error`=1 and `Halted`=1 after 7 EXEC cycles, and `Run`=0.
